// File: rtl/univ_shift_reg.sv
// Universal shift register: load, logical/arithmetic shifts, rotates, clear.
// Flags par/zero are decoded from the registered value.
module univ_shift_reg #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             par,
  output logic             zero
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHL   = 3'b010,
    M_SHR   = 3'b011,
    M_ROL   = 3'b100,
    M_ROR   = 3'b101,
    M_ASR   = 3'b110,
    M_CLEAR = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;
  mode_e            op;

  assign op = mode_e'(mode);

  always_comb begin
    q_nxt    = q;
    sout_nxt = sout;
    unique case (op)
      M_HOLD: begin
        q_nxt = q;
      end
      M_LOAD: begin
        q_nxt = d;
      end
      M_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin};
        sout_nxt = q[WIDTH-1];
      end
      M_SHR: begin
        q_nxt    = {sin, q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      M_ROL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_nxt = q[WIDTH-1];
      end
      M_ROR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      M_ASR: begin
        q_nxt    = {q[WIDTH-1], q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      M_CLEAR: begin
        q_nxt    = RST_VAL;
        sout_nxt = 1'b0;
      end
      default: begin
        q_nxt    = q;
        sout_nxt = sout;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= RST_VAL;
      sout <= 1'b0;
    end else if (en) begin
      q    <= q_nxt;
      sout <= sout_nxt;
    end
  end

  assign par  = ^q;
  assign zero = (q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed cases plus random ops against
// an arithmetic reference model, two instances (RST_VAL 0 and 0x5A).
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'd0;
  logic       sin = 1'b0;

  logic [7:0] q0, q1;
  logic       so0, so1, par0, par1, z0, z1;

  int checks = 0;
  int errors = 0;
  int mq[2];
  int ms[2];
  int rv[2] = '{0, 'h5A};

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .d(d), .sin(sin), .q(q0), .sout(so0),
    .par(par0), .zero(z0)
  );

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h5A)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .d(d), .sin(sin), .q(q1), .sout(so1),
    .par(par1), .zero(z1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic mdl_step(input int i);
    int v;
    v = mq[i];
    if (rst) begin
      mq[i] = rv[i];
      ms[i] = 0;
    end else if (en) begin
      case (mode)
        3'd1: mq[i] = d;
        3'd2: begin
          mq[i] = (v * 2 + sin) % 256;
          ms[i] = v / 128;
        end
        3'd3: begin
          mq[i] = v / 2 + sin * 128;
          ms[i] = v % 2;
        end
        3'd4: begin
          mq[i] = (v * 2) % 256 + v / 128;
          ms[i] = v / 128;
        end
        3'd5: begin
          mq[i] = v / 2 + (v % 2) * 128;
          ms[i] = v % 2;
        end
        3'd6: begin
          mq[i] = v / 2 + (v / 128) * 128;
          ms[i] = v % 2;
        end
        3'd7: begin
          mq[i] = rv[i];
          ms[i] = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input logic [2:0] m,
                      input logic [7:0] dd,
                      input logic s);
    rst  = r;
    en   = e;
    mode = m;
    d    = dd;
    sin  = s;
    @(posedge clk);
    mdl_step(0);
    mdl_step(1);
    #1;
    chk("q0", q0, mq[0]);
    chk("sout0", so0, ms[0]);
    chk("par0", par0, $countones(mq[0]) % 2);
    chk("zero0", z0, mq[0] == 0);
    chk("q1", q1, mq[1]);
    chk("sout1", so1, ms[1]);
    chk("par1", par1, $countones(mq[1]) % 2);
    chk("zero1", z1, mq[1] == 0);
  endtask

  logic [7:0] sv_q;
  logic       sv_s;

  initial begin
    // reset and load
    step(1, 0, 3'd5, 8'hFF, 1);
    chk("rst_q", q0, 8'h00);
    chk("rst_sout", so0, 1'b0);
    chk("rst_zero", z0, 1'b1);
    chk("rst_par", par0, 1'b0);
    chk("rst_q1", q1, 8'h5A);
    step(0, 1, 3'd1, 8'hA5, 0);
    chk("ld_q", q0, 8'hA5);
    chk("ld_par", par0, 1'b0);
    chk("ld_zero", z0, 1'b0);

    // shl then shr
    step(0, 1, 3'd1, 8'h81, 0);
    step(0, 1, 3'd2, 8'h00, 1);
    chk("shl_q", q0, 8'h03);
    chk("shl_sout", so0, 1'b1);
    step(0, 1, 3'd3, 8'hFF, 0);
    chk("shr_q", q0, 8'h01);
    chk("shr_sout", so0, 1'b1);

    // eight rotates return the value
    step(0, 1, 3'd1, 8'h96, 0);
    step(0, 1, 3'd4, 8'h00, 0);
    chk("rol1_q", q0, 8'h2D);
    chk("rol1_sout", so0, 1'b1);
    for (int i = 1; i < 8; i++) step(0, 1, 3'd4, 8'h00, 1);
    chk("rol8_q", q0, 8'h96);
    for (int i = 0; i < 8; i++) step(0, 1, 3'd5, 8'h11, 1);
    chk("ror8_q", q0, 8'h96);

    // asr converges to all ones
    step(0, 1, 3'd1, 8'h80, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 3'd6, 8'h00, 0);
    chk("asr7_q", q0, 8'hFF);
    step(0, 1, 3'd6, 8'h00, 0);
    chk("asr8_q", q0, 8'hFF);
    chk("asr8_sout", so0, 1'b1);

    // enable low holds everything
    sv_q = q0;
    sv_s = so0;
    for (int i = 0; i < 3; i++) step(0, 0, 3'd1, 8'h3C, 1);
    chk("en0_q", q0, sv_q);
    chk("en0_sout", so0, sv_s);
    step(0, 1, 3'd1, 8'h3C, 0);
    chk("en1_q", q0, 8'h3C);

    // reset mid shift sequence, then clear
    step(0, 1, 3'd2, 8'h00, 1);
    step(0, 1, 3'd2, 8'h00, 1);
    step(1, 1, 3'd2, 8'h00, 1);
    chk("rstmid_q0", q0, 8'h00);
    chk("rstmid_q1", q1, 8'h5A);
    step(0, 1, 3'd2, 8'h00, 1);
    chk("resume_q1", q1, 8'hB5);
    step(0, 1, 3'd7, 8'hFF, 1);
    chk("clr_q1", q1, 8'h5A);
    chk("clr_sout1", so1, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 25) == 0,
           ($urandom % 5) != 0,
           3'($urandom),
           8'($urandom),
           1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be legal for any value >= 2.
REQ-002 Parameter RST_VAL, default 0 (WIDTH bits), value loaded into q on reset and on CLEAR.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 en  input  1  clock enable; when low, all state SHALL hold regardless of mode.
REQ-006 mode  input  3  operation select (encoding in REQ-010).
REQ-007 d  input  WIDTH  parallel load data.
REQ-008 sin  input  1  serial input for logical shifts.
REQ-009 q  output  WIDTH  register contents; sout  output  1  bit shifted out on the last shift; par  output  1  even parity of q; zero  output  1  high when q == 0.

Function
REQ-010 On each rising clk edge with rst low and en high, q SHALL update per mode:
- 000 HOLD: q unchanged.
- 001 LOAD: q <= d.
- 010 SHL: q <= {q[WIDTH-2:0], sin}; sout <= q[WIDTH-1].
- 011 SHR: q <= {sin, q[WIDTH-1:1]}; sout <= q[0].
- 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; sout <= q[WIDTH-1].
- 101 ROR: q <= {q[0], q[WIDTH-1:1]}; sout <= q[0].
- 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; sout <= q[0].
- 111 CLEAR: q <= RST_VAL; sout <= 0.
REQ-011 sout SHALL hold its value in HOLD and LOAD modes and whenever en is low.
REQ-012 Latency: every operation SHALL be visible on q exactly one clk edge after it is sampled; no combinational path from d, sin or mode to q or sout.
REQ-013 par and zero SHALL be combinational functions of the registered q only, valid in the same cycle as q.
REQ-014 sin SHALL be ignored in all modes except SHL and SHR.
REQ-015 d SHALL be ignored in all modes except LOAD.
REQ-016 WIDTH rotations in one direction SHALL return q to its original value; rotations SHALL lose no bits.
REQ-017 ASR of a value with MSB 1 SHALL converge to all ones after WIDTH-1 shifts and stay there.
REQ-018 Mode changes between consecutive cycles SHALL take effect on the next edge; no mode requires a setup cycle.
REQ-019 Every register bit SHALL be a positive-edge D storage element; no latches.

Reset
REQ-020 With rst high at a rising edge, q SHALL become RST_VAL and sout 0, regardless of en, mode, d and sin.
REQ-021 rst SHALL take priority over every operation, including an in-progress shift sequence; the first edge with rst low SHALL resume normal operation from RST_VAL.
REQ-022 Before the first reset edge, outputs are undefined; the bench SHALL NOT check them before reset.

Verification
REQ-023 WIDTH=8: rst 1 cycle -> q=0x00, sout=0, zero=1, par=0; then LOAD d=0xA5 -> q=0xA5, par=0, zero=0.
REQ-024 q=0x81, SHL sin=1 -> q=0x03, sout=1; then SHR sin=0 -> q=0x01, sout=1.
REQ-025 q=0x96, 8 ROL -> q=0x96 after the 8th edge; first ROL gives q=0x2D, sout=1.
REQ-026 q=0x80, 7 ASR -> q=0xFF; an 8th ASR keeps q=0xFF, sout=1.
REQ-027 en=0 with mode=LOAD d=0x3C for 3 cycles -> q and sout unchanged; then en=1 -> q=0x3C.
REQ-028 rst asserted mid-sequence of SHL with en=1 -> q=RST_VAL next edge; repeat with RST_VAL=0x5A, and CLEAR mode -> q=0x5A, sout=0.
